ysyx_23060221_ifu: RTL and testbench

Instruction fetch unit for the multicycle NPC core. Holds the PC and issues one 32-bit fetch per instruction on a valid/ready request/response memory port. It drives the fetched instruction and its PC into the decode stage with a valid/ready handshake (IFU_valid / IDU_ready), then waits for the next PC from writeback before fetching again. It is the producer end of the fetch-to-decode handshake whose consumer is the decode stage.

---
 rtl/ysyx_23060221_ifu_pkg.sv | 19 +
 rtl/ysyx_23060221_ifu_if.sv | 28 ++
 rtl/ysyx_23060221_ifu.sv | 103 ++++++++++
 tb/tb_ysyx_23060221_ifu.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060221_ifu_pkg.sv
// Shared types and constants for the NPC instruction fetch unit.
// Holds the FSM state encoding, reset PC and the alignment helper.
package ysyx_23060221_ifu_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_REQ      = 3'd0,
    ST_WAIT     = 3'd1,
    ST_HOLD     = 3'd2,
    ST_WAIT_NPC = 3'd3,
    ST_FAULT    = 3'd4
  } ifu_state_e;

  function automatic logic pc_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_23060221_ifu_if.sv
// Fetch memory port: valid/ready request channel plus a response channel.
// The IFU is the master; the instruction memory is the slave.
interface ysyx_23060221_ifu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    input  mem_rsp_err
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data,
    output mem_rsp_err
  );
endinterface

// File: rtl/ysyx_23060221_ifu.sv
// Instruction fetch unit: one fetch per instruction, handed to decode,
// then waits for writeback's next PC. Bus errors and misaligned PCs park it in FAULT.
module ysyx_23060221_ifu
  import ysyx_23060221_ifu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  ysyx_23060221_ifu_if.master        mem,
  output logic [31:0]                inst,
  output logic [31:0]                pc,
  output logic                       IFU_valid,
  input  logic                       IDU_ready,
  input  logic                       npc_valid,
  input  logic [31:0]                npc,
  output logic                       fetch_fault,
  output logic [31:0]                fetch_cnt
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_valid_q, req_valid_d;

  // State, datapath and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      inst_q      <= 32'h0000_0000;
      cnt_q       <= 32'h0000_0000;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
    end
  end

  // Next-state and datapath updates; each input is only looked at in its own state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_REQ: begin
        // req_valid_q is low in the first cycle out of reset, so no acceptance there.
        if (req_valid_q && mem.mem_req_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem.mem_rsp_valid) begin
          if (mem.mem_rsp_err) begin
            state_d = ST_FAULT;
          end else begin
            inst_d  = mem.mem_rsp_data;
            state_d = ST_HOLD;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (IDU_ready) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = ST_WAIT_NPC;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_WAIT_NPC: begin
        if (npc_valid) begin
          if (pc_aligned(npc[1:0])) begin
            pc_d    = npc;
            state_d = ST_REQ;
          end else begin
            state_d = ST_FAULT;
          end
        end else begin
          state_d = ST_WAIT_NPC;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
    req_valid_d = (state_d == ST_REQ);
  end

  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_addr  = pc_q;
  assign inst              = inst_q;
  assign pc                = pc_q;
  assign IFU_valid         = (state_q == ST_HOLD);
  assign fetch_fault       = (state_q == ST_FAULT);
  assign fetch_cnt         = cnt_q;

endmodule

// File: tb/tb_ysyx_23060221_ifu.sv
// Self-checking bench for ysyx_23060221_ifu against a transaction-level model
// (expected pc, handshake count) with randomized memory/decode/writeback timing.
module tb_ysyx_23060221_ifu;
  import ysyx_23060221_ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        IDU_ready;
  logic        npc_valid;
  logic [31:0] npc;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        IFU_valid;
  logic        fetch_fault;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  ysyx_23060221_ifu_if mif ();

  ysyx_23060221_ifu dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (mif),
    .inst        (inst),
    .pc          (pc),
    .IFU_valid   (IFU_valid),
    .IDU_ready   (IDU_ready),
    .npc_valid   (npc_valid),
    .npc         (npc),
    .fetch_fault (fetch_fault),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    IDU_ready = 1'b0; npc_valid = 1'b0; npc = 32'h0000_0000;
    mif.mem_req_ready = 1'b0; mif.mem_rsp_valid = 1'b0;
    mif.mem_rsp_data = 32'h0000_0000; mif.mem_rsp_err = 1'b0;
    tick; tick;
    rst = 1'b0;
    m_pc = RESET_PC;
    m_cnt = 32'd0;
    tick;
  endtask

  // One fetch starting in REQ with the request visible; ends in WAIT_NPC.
  task automatic fetch_one(input logic [31:0] data, input int rdy_dly, input int rsp_dly,
                           input int idu_dly);
    logic [31:0] junk;
    for (int i = 0; i < rdy_dly; i++) begin
      mif.mem_req_ready = 1'b0;
      tick;
      n_checks++;
      if (mif.mem_req_valid !== 1'b1 || mif.mem_req_addr !== m_pc) begin
        n_fail++;
        $display("FAIL req_stall valid=%0b addr=%h expected valid=1 addr=%h",
                 mif.mem_req_valid, mif.mem_req_addr, m_pc);
      end
    end
    n_checks++;
    if (mif.mem_req_valid !== 1'b1 || mif.mem_req_addr !== m_pc) begin
      n_fail++;
      $display("FAIL req_issue valid=%0b addr=%h expected valid=1 addr=%h",
               mif.mem_req_valid, mif.mem_req_addr, m_pc);
    end
    // Response in the acceptance cycle must be discarded.
    junk = $urandom;
    mif.mem_req_ready = 1'b1;
    mif.mem_rsp_valid = 1'b1; mif.mem_rsp_data = junk; mif.mem_rsp_err = $urandom_range(1, 0) == 1;
    tick;
    mif.mem_req_ready = 1'b0; mif.mem_rsp_valid = 1'b0; mif.mem_rsp_err = 1'b0;
    n_checks++;
    if (mif.mem_req_valid !== 1'b0 || IFU_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL accept valid=%0b ifu_valid=%0b fault=%0b expected 0 0 0",
               mif.mem_req_valid, IFU_valid, fetch_fault);
    end
    for (int i = 0; i < rsp_dly; i++) begin
      npc_valid = 1'b1; npc = $urandom;
      tick;
      npc_valid = 1'b0;
      n_checks++;
      if (IFU_valid !== 1'b0 || mif.mem_req_valid !== 1'b0 || pc !== m_pc) begin
        n_fail++;
        $display("FAIL wait_rsp ifu_valid=%0b req_valid=%0b pc=%h expected 0 0 %h",
                 IFU_valid, mif.mem_req_valid, pc, m_pc);
      end
    end
    mif.mem_rsp_valid = 1'b1; mif.mem_rsp_data = data;
    tick;
    mif.mem_rsp_valid = 1'b0;
    for (int i = 0; i <= idu_dly; i++) begin
      n_checks++;
      if (IFU_valid !== 1'b1 || inst !== data || pc !== m_pc) begin
        n_fail++;
        $display("FAIL hold ifu_valid=%0b inst=%h pc=%h expected 1 %h %h",
                 IFU_valid, inst, pc, data, m_pc);
      end
      if (i < idu_dly) begin
        IDU_ready = 1'b0; npc_valid = 1'b1; npc = $urandom;
        mif.mem_rsp_valid = 1'b1; mif.mem_rsp_data = $urandom;
        tick;
        npc_valid = 1'b0; mif.mem_rsp_valid = 1'b0;
      end
    end
    IDU_ready = 1'b1;
    tick;
    IDU_ready = 1'b0;
    m_cnt = m_cnt + 32'd1;
    n_checks++;
    if (IFU_valid !== 1'b0 || fetch_cnt !== m_cnt || mif.mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake ifu_valid=%0b cnt=%0d req_valid=%0b expected 0 %0d 0",
               IFU_valid, fetch_cnt, mif.mem_req_valid, m_cnt);
    end
  endtask

  // Writeback presents nv after dly idle cycles in WAIT_NPC.
  task automatic give_npc(input logic [31:0] nv, input int dly);
    for (int i = 0; i < dly; i++) begin
      mif.mem_req_ready = 1'b1;
      tick;
      mif.mem_req_ready = 1'b0;
      n_checks++;
      if (mif.mem_req_valid !== 1'b0 || IFU_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_npc req_valid=%0b ifu_valid=%0b expected 0 0",
                 mif.mem_req_valid, IFU_valid);
      end
    end
    npc_valid = 1'b1; npc = nv;
    tick;
    npc_valid = 1'b0;
    if (nv[1:0] == 2'b00) begin
      m_pc = nv;
      n_checks++;
      if (mif.mem_req_valid !== 1'b1 || mif.mem_req_addr !== nv || fetch_fault !== 1'b0) begin
        n_fail++;
        $display("FAIL npc_req valid=%0b addr=%h fault=%0b expected 1 %h 0",
                 mif.mem_req_valid, mif.mem_req_addr, fetch_fault, nv);
      end
    end else begin
      n_checks++;
      if (fetch_fault !== 1'b1 || mif.mem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL npc_misaligned fault=%0b req_valid=%0b expected 1 0",
                 fetch_fault, mif.mem_req_valid);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    IDU_ready = 1'b0; npc_valid = 1'b0; npc = 32'h0000_0000;
    mif.mem_req_ready = 1'b0; mif.mem_rsp_valid = 1'b0;
    mif.mem_rsp_data = 32'h0000_0000; mif.mem_rsp_err = 1'b0;
    tick; tick;
    n_checks++;
    if (mif.mem_req_valid !== 1'b0 || pc !== 32'h8000_0000 || inst !== 32'h0 ||
        IFU_valid !== 1'b0 || fetch_fault !== 1'b0 || fetch_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values req_valid=%0b pc=%h inst=%h ifu_valid=%0b fault=%0b cnt=%0d expected 0 80000000 0 0 0 0",
               mif.mem_req_valid, pc, inst, IFU_valid, fetch_fault, fetch_cnt);
    end
    rst = 1'b0;
    m_pc = RESET_PC;
    m_cnt = 32'd0;
    tick;
    n_checks++;
    if (mif.mem_req_valid !== 1'b1 || mif.mem_req_addr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL reset_first_req valid=%0b addr=%h expected 1 80000000",
               mif.mem_req_valid, mif.mem_req_addr);
    end
  endtask

  task automatic test_zero_wait;
    fetch_one(32'h0000_0413, 0, 0, 0);
    give_npc(32'h8000_0004, 0);
  endtask

  task automatic test_req_stall;
    fetch_one(32'h0010_0093, 3, 1, 0);
    give_npc(32'h8000_0010, 2);
  endtask

  task automatic test_idu_stall;
    fetch_one(32'h0020_8113, 0, 2, 5);
    give_npc(32'h8000_0014, 1);
  endtask

  task automatic test_random;
    logic [31:0] nv;
    for (int k = 0; k < 20; k++) begin
      nv = $urandom;
      nv[1:0] = 2'b00;
      fetch_one($urandom, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0));
      give_npc(nv, $urandom_range(2, 0));
    end
  endtask

  task automatic test_fault_rsp;
    do_reset;
    mif.mem_req_ready = 1'b1;
    tick;
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b1; mif.mem_rsp_err = 1'b1; mif.mem_rsp_data = $urandom;
    tick;
    mif.mem_rsp_valid = 1'b0; mif.mem_rsp_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (fetch_fault !== 1'b1 || mif.mem_req_valid !== 1'b0 || IFU_valid !== 1'b0 ||
          pc !== RESET_PC) begin
        n_fail++;
        $display("FAIL fault_rsp fault=%0b req_valid=%0b ifu_valid=%0b pc=%h expected 1 0 0 %h",
                 fetch_fault, mif.mem_req_valid, IFU_valid, pc, RESET_PC);
      end
      mif.mem_req_ready = 1'b1; npc_valid = 1'b1; npc = 32'h8000_0040; IDU_ready = 1'b1;
      tick;
      mif.mem_req_ready = 1'b0; npc_valid = 1'b0; IDU_ready = 1'b0;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++;
    if (fetch_fault !== 1'b0 || pc !== 32'h8000_0000 || fetch_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL fault_rsp_reset fault=%0b pc=%h cnt=%0d expected 0 80000000 0",
               fetch_fault, pc, fetch_cnt);
    end
  endtask

  task automatic test_fault_npc;
    do_reset;
    fetch_one(32'h0000_0013, 0, 0, 0);
    give_npc(32'h8000_0002, 0);
    mif.mem_req_ready = 1'b1; npc_valid = 1'b1; npc = 32'h8000_0008;
    tick; tick;
    mif.mem_req_ready = 1'b0; npc_valid = 1'b0;
    n_checks++;
    if (fetch_fault !== 1'b1 || mif.mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_npc_sticky fault=%0b req_valid=%0b expected 1 0",
               fetch_fault, mif.mem_req_valid);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++;
    if (fetch_fault !== 1'b0 || pc !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL fault_npc_reset fault=%0b pc=%h expected 0 80000000", fetch_fault, pc);
    end
  endtask

  task automatic test_reset_in_wait;
    do_reset;
    fetch_one(32'h0030_0193, 0, 0, 0);
    give_npc(32'h8000_0100, 0);
    mif.mem_req_ready = 1'b1;
    tick;
    mif.mem_req_ready = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mif.mem_rsp_valid = 1'b1; mif.mem_rsp_data = 32'hDEAD_BEEF; mif.mem_rsp_err = 1'b0;
    tick;
    n_checks++;
    if (IFU_valid !== 1'b0 || mif.mem_req_valid !== 1'b1 ||
        mif.mem_req_addr !== 32'h8000_0000 || fetch_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL stray_rsp ifu_valid=%0b req_valid=%0b addr=%h cnt=%0d expected 0 1 80000000 0",
               IFU_valid, mif.mem_req_valid, mif.mem_req_addr, fetch_cnt);
    end
    tick;
    mif.mem_rsp_valid = 1'b0;
    n_checks++;
    if (IFU_valid !== 1'b0 || inst !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL stray_rsp_hold ifu_valid=%0b inst=%h expected 0 00000000", IFU_valid, inst);
    end
    m_pc = RESET_PC;
    m_cnt = 32'd0;
    fetch_one(32'h0040_0213, 1, 1, 1);
    give_npc(32'h8000_0200, 0);
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_req_stall;
    test_idu_stall;
    test_random;
    test_fault_rsp;
    test_fault_npc;
    test_reset_in_wait;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
